// File: rtl/stream_arbiter.sv
// Two-source AXI-Stream packet arbiter, round-robin on ties, one packet per grant.
// Latency: 1 cycle input beat to m01 output register, plus a 1-cycle bubble per grant.
// Backpressure: owner tready drops while the output register is full and m01 is stalled.
module stream_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 4096,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,

  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,

  input  logic [DATA_WIDTH-1:0]   s02_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s02_axis_tstrb,
  input  logic                    s02_axis_tvalid,
  input  logic                    s02_axis_tlast,
  output logic                    s02_axis_tready,

  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,

  output logic [1:0]              grant,
  output logic [CNT_WIDTH-1:0]    pkt_cnt01,
  output logic [CNT_WIDTH-1:0]    pkt_cnt02,
  output logic                    overrun
);

  localparam int BW = $clog2(MAX_BEATS) + 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, GNT01, GNT02} state_t;

  state_t          state, state_nxt;
  logic            last_owner;  // 0 = s01, 1 = s02
  logic [BW-1:0]   beat_cnt;

  logic            out_free;
  logic            acc01, acc02, acc;
  logic [DATA_WIDTH-1:0] in_tdata;
  logic [SW-1:0]   in_tstrb;
  logic            in_tlast;
  logic            cnt_limit;
  logic            force_last;
  logic            pkt_end;

  assign out_free        = !m01_axis_tvalid || m01_axis_tready;
  assign s01_axis_tready = (state == GNT01) && out_free;
  assign s02_axis_tready = (state == GNT02) && out_free;

  assign acc01 = s01_axis_tvalid && s01_axis_tready;
  assign acc02 = s02_axis_tvalid && s02_axis_tready;
  assign acc   = acc01 || acc02;

  assign in_tdata = (state == GNT02) ? s02_axis_tdata : s01_axis_tdata;
  assign in_tstrb = (state == GNT02) ? s02_axis_tstrb : s01_axis_tstrb;
  assign in_tlast = (state == GNT02) ? s02_axis_tlast : s01_axis_tlast;

  // A packet that reaches MAX_BEATS without tlast is cut and closed here.
  assign cnt_limit  = (beat_cnt == BW'(MAX_BEATS - 1));
  assign force_last = !in_tlast && cnt_limit;
  assign pkt_end    = acc && (in_tlast || cnt_limit);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (s01_axis_tvalid && s02_axis_tvalid)
          state_nxt = last_owner ? GNT01 : GNT02;
        else if (s01_axis_tvalid)
          state_nxt = GNT01;
        else if (s02_axis_tvalid)
          state_nxt = GNT02;
      end
      GNT01, GNT02: begin
        if (pkt_end)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant = 2'b00;
    case (state)
      GNT01:   grant = 2'b01;
      GNT02:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state           <= IDLE;
      last_owner      <= 1'b1;
      beat_cnt        <= '0;
      m01_axis_tdata  <= '0;
      m01_axis_tstrb  <= '0;
      m01_axis_tlast  <= 1'b0;
      m01_axis_tvalid <= 1'b0;
      pkt_cnt01       <= '0;
      pkt_cnt02       <= '0;
      overrun         <= 1'b0;
    end else begin
      state <= state_nxt;

      // Holding the count at zero while idle clears it for every new grant.
      if (state == IDLE)
        beat_cnt <= '0;
      else if (acc)
        beat_cnt <= beat_cnt + BW'(1);

      if (acc) begin
        m01_axis_tdata  <= in_tdata;
        m01_axis_tstrb  <= in_tstrb;
        m01_axis_tlast  <= in_tlast || force_last;
        m01_axis_tvalid <= 1'b1;
      end else if (m01_axis_tready) begin
        m01_axis_tvalid <= 1'b0;
      end

      if (pkt_end) begin
        last_owner <= (state == GNT02);
        if (state == GNT02)
          pkt_cnt02 <= pkt_cnt02 + CNT_WIDTH'(1);
        else
          pkt_cnt01 <= pkt_cnt01 + CNT_WIDTH'(1);
        if (force_last)
          overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter (MAX_BEATS=4, CNT_WIDTH=2 so overrun and wrap are reachable).
module tb_stream_arbiter;

  logic        axis_aclk = 1'b0;
  logic        axis_aresetn = 1'b0;
  logic [31:0] s01_tdata = '0, s02_tdata = '0;
  logic [3:0]  s01_tstrb = '0, s02_tstrb = '0;
  logic        s01_tvalid = 1'b0, s02_tvalid = 1'b0;
  logic        s01_tlast = 1'b0, s02_tlast = 1'b0;
  logic        s01_tready, s02_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic [1:0]  grant;
  logic [1:0]  pkt_cnt01, pkt_cnt02;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  logic [32:0] q01[$];
  logic [32:0] q02[$];
  logic [36:0] out_q[$];
  logic [1:0]  gnt_q[$];
  logic [1:0]  grant_prev = 2'b00;
  int          acc01_n = 0;

  always #5 axis_aclk = ~axis_aclk;

  stream_arbiter #(.DATA_WIDTH(32), .MAX_BEATS(4), .CNT_WIDTH(2)) dut (
    .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
    .s01_axis_tdata(s01_tdata), .s01_axis_tstrb(s01_tstrb), .s01_axis_tvalid(s01_tvalid),
    .s01_axis_tlast(s01_tlast), .s01_axis_tready(s01_tready),
    .s02_axis_tdata(s02_tdata), .s02_axis_tstrb(s02_tstrb), .s02_axis_tvalid(s02_tvalid),
    .s02_axis_tlast(s02_tlast), .s02_axis_tready(s02_tready),
    .m01_axis_tdata(m_tdata), .m01_axis_tstrb(m_tstrb), .m01_axis_tvalid(m_tvalid),
    .m01_axis_tlast(m_tlast), .m01_axis_tready(m_tready),
    .grant(grant), .pkt_cnt01(pkt_cnt01), .pkt_cnt02(pkt_cnt02), .overrun(overrun)
  );

  // Expected output word {tlast, tstrb, tdata}; sources drive tstrb = ~tdata[3:0].
  function automatic logic [36:0] exp_beat(input logic [31:0] d, input logic l);
    return {l, ~d[3:0], d};
  endfunction

  task automatic wait_out(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge axis_aclk);
      if (out_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge axis_aclk);
    axis_aresetn = 1'b0;
    q01.delete();
    q02.delete();
    m_tready = 1'b1;
    @(negedge axis_aclk);
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    out_q.delete();
    gnt_q.delete();
  endtask

  task automatic test_reset();
    @(negedge axis_aclk);
    @(negedge axis_aclk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_tlast); end
    checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
    checks++; if (m_tstrb !== 4'h0) begin errors++; $display("FAIL reset_tstrb got=%h exp=0", m_tstrb); end
    checks++; if ({s01_tready, s02_tready} !== 2'b00) begin errors++; $display("FAIL reset_tready got=%b exp=00", {s01_tready, s02_tready}); end
    checks++; if ({pkt_cnt01, pkt_cnt02} !== 4'h0) begin errors++; $display("FAIL reset_cnts got=%h exp=0", {pkt_cnt01, pkt_cnt02}); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    axis_aresetn = 1'b1;
  endtask

  task automatic test_latency();
    int n0 = -1;
    int n1 = -1;
    @(negedge axis_aclk);
    for (int k = 0; k < 4; k++) q01.push_back({(k == 3), 32'hA0 + k});
    for (int i = 0; i < 40; i++) begin
      @(negedge axis_aclk);
      if (n0 < 0 && s01_tvalid) n0 = i;
      if (n1 < 0 && m_tvalid) n1 = i;
      if (out_q.size() >= 4) break;
    end
    checks++; if (n1 - n0 !== 2) begin errors++; $display("FAIL latency_cycles got=%0d exp=2", n1 - n0); end
    checks++;
    if (out_q.size() !== 4) begin
      errors++; $display("FAIL latency_count got=%0d exp=4", out_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (out_q[k] !== exp_beat(32'hA0 + k, k == 3)) begin
          errors++; $display("FAIL latency_beat%0d got=%h exp=%h", k, out_q[k], exp_beat(32'hA0 + k, k == 3));
        end
      end
    end
    @(negedge axis_aclk);
    checks++; if (pkt_cnt01 !== 2'd1) begin errors++; $display("FAIL latency_pkt_cnt01 got=%0d exp=1", pkt_cnt01); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL latency_no_overrun got=%b exp=0", overrun); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL latency_idle_grant got=%b exp=00", grant); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [31:0] exp_d[8];
    exp_d = '{32'h11, 32'h12, 32'h21, 32'h22, 32'h13, 32'h14, 32'h23, 32'h24};
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 2; k++) begin
        q01.push_back({(k == 1), 32'h11 + 2 * p + k});
        q02.push_back({(k == 1), 32'h21 + 2 * p + k});
      end
    end
    wait_out(8, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got=%0d beats exp=8", out_q.size()); end
    @(negedge axis_aclk);
    checks++;
    if (gnt_q.size() !== 4) begin
      errors++; $display("FAIL rr_grant_count got=%0d exp=4", gnt_q.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (gnt_q[g] !== ((g % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL rr_grant%0d got=%b exp=%b", g, gnt_q[g], (g % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
    end
    if (out_q.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (out_q[k] !== exp_beat(exp_d[k], k % 2 == 1)) begin
          errors++; $display("FAIL rr_beat%0d got=%h exp=%h", k, out_q[k], exp_beat(exp_d[k], k % 2 == 1));
        end
      end
    end
    checks++; if ({pkt_cnt01, pkt_cnt02} !== {2'd2, 2'd2}) begin errors++; $display("FAIL rr_cnts got=%0d,%0d exp=2,2", pkt_cnt01, pkt_cnt02); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen = 1'b0;
    bit stalled = 1'b0;
    logic [31:0] held = '0;
    logic pat[8];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 3; k++) q02.push_back({(k == 2), 32'hB0 + k});
    for (int i = 0; i < 20; i++) begin
      @(negedge axis_aclk);
      if (m_tvalid) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_start_timeout got=no tvalid exp=tvalid"); end
    for (int i = 0; i < 8; i++) begin
      m_tready = pat[i];
      #1;
      if (m_tvalid && !m_tready) begin
        checks++; if (s02_tready !== 1'b0) begin errors++; $display("FAIL bp_s02_tready cyc%0d got=%b exp=0", i, s02_tready); end
        if (stalled) begin
          checks++; if (m_tdata !== held) begin errors++; $display("FAIL bp_stable cyc%0d got=%h exp=%h", i, m_tdata, held); end
        end
        held = m_tdata;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      @(negedge axis_aclk);
    end
    m_tready = 1'b1;
    wait_out(3, 20, ok);
    checks++;
    if (out_q.size() !== 3) begin
      errors++; $display("FAIL bp_count got=%0d exp=3", out_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (out_q[k] !== exp_beat(32'hB0 + k, k == 2)) begin
          errors++; $display("FAIL bp_beat%0d got=%h exp=%h", k, out_q[k], exp_beat(32'hB0 + k, k == 2));
        end
      end
    end
    checks++; if (pkt_cnt02 !== 2'd1) begin errors++; $display("FAIL bp_pkt_cnt02 got=%0d exp=1", pkt_cnt02); end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    for (int k = 0; k < 6; k++) q01.push_back({1'b0, 32'hC0 + k});
    wait_out(6, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_timeout got=%0d beats exp=6", out_q.size()); end
    @(negedge axis_aclk);
    if (out_q.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (out_q[k] !== exp_beat(32'hC0 + k, k == 3)) begin
          errors++; $display("FAIL ovr_beat%0d got=%h exp=%h", k, out_q[k], exp_beat(32'hC0 + k, k == 3));
        end
      end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    checks++; if (pkt_cnt01 !== 2'd1) begin errors++; $display("FAIL ovr_pkt_cnt01 got=%0d exp=1", pkt_cnt01); end
    checks++; if (gnt_q.size() !== 2) begin errors++; $display("FAIL ovr_grants got=%0d exp=2", gnt_q.size()); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ovr_open_grant got=%b exp=01", grant); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    bit hit = 1'b0;
    do_reset();
    base = acc01_n;
    for (int k = 0; k < 4; k++) q01.push_back({(k == 3), 32'hD0 + k});
    for (int i = 0; i < 20; i++) begin
      @(negedge axis_aclk);
      if (acc01_n - base >= 2) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_timeout got=%0d accepts exp=2", acc01_n - base); end
    axis_aresetn = 1'b0;
    q01.delete();
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rstmid_grant got=%b exp=00", grant); end
    checks++; if ({pkt_cnt01, pkt_cnt02} !== 4'h0) begin errors++; $display("FAIL rstmid_cnts got=%h exp=0", {pkt_cnt01, pkt_cnt02}); end
    out_q.delete();
    q01.push_back({1'b0, 32'hE0});
    q01.push_back({1'b1, 32'hE1});
    wait_out(2, 30, ok);
    @(negedge axis_aclk);
    checks++;
    if (out_q.size() !== 2) begin
      errors++; $display("FAIL rstmid_count got=%0d exp=2", out_q.size());
    end else begin
      checks++; if (out_q[0] !== exp_beat(32'hE0, 1'b0)) begin errors++; $display("FAIL rstmid_beat0 got=%h exp=%h", out_q[0], exp_beat(32'hE0, 1'b0)); end
      checks++; if (out_q[1] !== exp_beat(32'hE1, 1'b1)) begin errors++; $display("FAIL rstmid_beat1 got=%h exp=%h", out_q[1], exp_beat(32'hE1, 1'b1)); end
    end
    checks++; if (pkt_cnt01 !== 2'd1) begin errors++; $display("FAIL rstmid_pkt_cnt01 got=%0d exp=1", pkt_cnt01); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    for (int k = 0; k < 5; k++) q02.push_back({1'b1, 32'hF0 + k});
    wait_out(5, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got=%0d beats exp=5", out_q.size()); end
    @(negedge axis_aclk);
    checks++; if (pkt_cnt02 !== 2'd1) begin errors++; $display("FAIL wrap_pkt_cnt02 got=%0d exp=1", pkt_cnt02); end
    checks++; if (pkt_cnt01 !== 2'd0) begin errors++; $display("FAIL wrap_pkt_cnt01 got=%0d exp=0", pkt_cnt01); end
    if (out_q.size() >= 5) begin
      checks++; if (out_q[4] !== exp_beat(32'hF4, 1'b1)) begin errors++; $display("FAIL wrap_last_beat got=%h exp=%h", out_q[4], exp_beat(32'hF4, 1'b1)); end
    end
  endtask

  initial begin
    fork
      forever begin
        @(posedge axis_aclk);
        if (s01_tvalid && s01_tready && q01.size() > 0) begin q01.delete(0); acc01_n++; end
        if (s02_tvalid && s02_tready && q02.size() > 0) q02.delete(0);
        if (axis_aresetn && m_tvalid && m_tready) out_q.push_back({m_tlast, m_tstrb, m_tdata});
        if (grant != 2'b00 && grant_prev == 2'b00) gnt_q.push_back(grant);
        grant_prev = grant;
        #1;
        if (q01.size() > 0) begin
          s01_tvalid = 1'b1; s01_tdata = q01[0][31:0]; s01_tlast = q01[0][32]; s01_tstrb = ~q01[0][3:0];
        end else begin
          s01_tvalid = 1'b0; s01_tlast = 1'b0;
        end
        if (q02.size() > 0) begin
          s02_tvalid = 1'b1; s02_tdata = q02[0][31:0]; s02_tlast = q02[0][32]; s02_tstrb = ~q02[0][3:0];
        end else begin
          s02_tvalid = 1'b0; s02_tlast = 1'b0;
        end
      end
    join_none

    test_reset();
    test_latency();
    test_round_robin();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_wrap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
